// File: rtl/timer_count_up.sv
// 4-digit BCD elapsed-time counter (MM:SS) that counts up from a loaded value
// and saturates at {MAX_MIN, 8'h59}, flagging arrival with a one-clock rco_L pulse.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_COUNT | ticks advance the count toward the maximum
// ST_FULL  | count parked at the maximum, ticks are ignored
module timer_count_up #(
  parameter int          SEC_TENS_MAX = 5,
  parameter logic [7:0]  MAX_MIN      = 8'h99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        enablen,
  input  logic        tick,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        full,
  output logic        rco_L
);

  localparam logic [15:0] MAX_VAL  = {MAX_MIN, 8'h59};
  localparam logic [3:0]  TENS_MAX = 4'(SEC_TENS_MAX);
  localparam logic [0:0]  ST_COUNT = 1'b0;
  localparam logic [0:0]  ST_FULL  = 1'b1;

  logic [15:0] cnt_q, cnt_d;
  logic [0:0]  state_q, state_d;
  logic        rco_l_q, rco_l_d;

  logic [15:0] din_s, load_val, inc_val;
  logic [3:0]  so_n, st_n, mo_n, mt_n;
  logic        c0, c1, c2;
  logic        advance;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
    return (nib > 4'd9) ? 4'd9 : nib;
  endfunction

  // Sanitised digits are all 0..9, so a plain unsigned compare orders them as BCD.
  always_comb begin
    din_s    = {clamp_bcd(din[15:12]), clamp_bcd(din[11:8]),
                clamp_bcd(din[7:4]),   clamp_bcd(din[3:0])};
    load_val = (din_s >= MAX_VAL) ? MAX_VAL : din_s;
  end

  always_comb begin
    so_n = cnt_q[3:0];
    st_n = cnt_q[7:4];
    mo_n = cnt_q[11:8];
    mt_n = cnt_q[15:12];
    c0   = 1'b0;
    c1   = 1'b0;
    c2   = 1'b0;
    if (cnt_q[3:0] >= 4'd9) begin
      so_n = 4'd0;
      c0   = 1'b1;
    end else begin
      so_n = cnt_q[3:0] + 4'd1;
    end
    // Tens loaded above the mod-6 limit still wrap into the next minute.
    if (c0) begin
      if (cnt_q[7:4] >= TENS_MAX) begin
        st_n = 4'd0;
        c1   = 1'b1;
      end else begin
        st_n = cnt_q[7:4] + 4'd1;
      end
    end
    if (c1) begin
      if (cnt_q[11:8] >= 4'd9) begin
        mo_n = 4'd0;
        c2   = 1'b1;
      end else begin
        mo_n = cnt_q[11:8] + 4'd1;
      end
    end
    if (c2) begin
      mt_n = (cnt_q[15:12] >= 4'd9) ? 4'd0 : cnt_q[15:12] + 4'd1;
    end
    inc_val = {mt_n, mo_n, st_n, so_n};
  end

  assign advance = ~enablen & tick & (state_q == ST_COUNT) & ~load;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    rco_l_d = 1'b1;
    if (load) begin
      cnt_d   = load_val;
      state_d = (load_val == MAX_VAL) ? ST_FULL : ST_COUNT;
    end else if (advance) begin
      cnt_d = inc_val;
      if (inc_val == MAX_VAL) begin
        state_d = ST_FULL;
        rco_l_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= 16'h0000;
      state_q <= ST_COUNT;
      rco_l_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rco_l_q <= rco_l_d;
    end
  end

  assign dout  = cnt_q;
  assign full  = (cnt_q == MAX_VAL);
  assign rco_L = rco_l_q;

endmodule

// File: tb/tb_timer_count_up.sv
// Directed bench for timer_count_up: inputs change just after the falling edge,
// outputs are checked at the next falling edge, half a clock after the update.
module tb_timer_count_up;

  logic        clk = 1'b0;
  logic        rst, load, enablen, tick;
  logic [15:0] din;
  logic [15:0] dout;
  logic        full, rco_L;
  int          tests_run = 0;
  int          failures  = 0;

  timer_count_up dut (
    .clk(clk), .rst(rst), .load(load), .enablen(enablen), .tick(tick),
    .din(din), .dout(dout), .full(full), .rco_L(rco_L)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: called just after a falling edge, return at the next one.
  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    din  = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b0; enablen = 1'b0; tick = 1'b0; din = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tests_run++;
    if (dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", dout); end
    tests_run++;
    if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    tests_run++;
    if (rco_L !== 1'b1) begin failures++; $display("FAIL reset_rco got=%b exp=1", rco_L); end
  endtask

  task automatic test_count();
    logic [15:0] exp, prev;
    prev = 16'h0000;
    for (int i = 1; i <= 10; i++) begin
      exp  = (i < 10) ? 16'(i) : 16'h0010;
      tick = 1'b1;
      #1;
      tests_run++;
      if (dout !== prev) begin failures++; $display("FAIL count_latency i=%0d got=%h exp=%h", i, dout, prev); end
      @(negedge clk);
      tick = 1'b0;
      tests_run++;
      if (dout !== exp) begin failures++; $display("FAIL count_step i=%0d got=%h exp=%h", i, dout, exp); end
      tests_run++;
      if (full !== 1'b0 || rco_L !== 1'b1) begin
        failures++; $display("FAIL count_flags i=%0d full=%b rco=%b exp full=0 rco=1", i, full, rco_L);
      end
      prev = exp;
    end
  endtask

  task automatic test_sec_rollover();
    do_load(16'h0759);
    do_tick();
    tests_run++;
    if (dout !== 16'h0800) begin failures++; $display("FAIL roll_0759 got=%h exp=0800", dout); end
    do_tick();
    tests_run++;
    if (dout !== 16'h0801) begin failures++; $display("FAIL roll_0800 got=%h exp=0801", dout); end
    do_load(16'h0999);
    do_tick();
    tests_run++;
    if (dout !== 16'h1000) begin failures++; $display("FAIL roll_0999 got=%h exp=1000", dout); end
  endtask

  task automatic test_tens_overflow();
    logic [15:0] seq [3];
    seq[0] = 16'h0300; seq[1] = 16'h0301; seq[2] = 16'h0302;
    do_load(16'h0279);
    tests_run++;
    if (dout !== 16'h0279) begin failures++; $display("FAIL tens_load got=%h exp=0279", dout); end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      tests_run++;
      if (dout !== seq[i]) begin failures++; $display("FAIL tens_step i=%0d got=%h exp=%h", i, dout, seq[i]); end
    end
    do_load(16'h0A5F);
    tests_run++;
    if (dout !== 16'h0959) begin failures++; $display("FAIL sanitise got=%h exp=0959", dout); end
  endtask

  task automatic test_saturate();
    do_load(16'h9958);
    tests_run++;
    if (full !== 1'b0) begin failures++; $display("FAIL sat_pre_full got=%b exp=0", full); end
    do_tick();
    tests_run++;
    if (dout !== 16'h9959 || full !== 1'b1) begin
      failures++; $display("FAIL sat_reach dout=%h full=%b exp 9959/1", dout, full);
    end
    tests_run++;
    if (rco_L !== 1'b0) begin failures++; $display("FAIL sat_rco_pulse got=%b exp=0", rco_L); end
    @(negedge clk);
    tests_run++;
    if (rco_L !== 1'b1) begin failures++; $display("FAIL sat_rco_width got=%b exp=1", rco_L); end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      tests_run++;
      if (dout !== 16'h9959 || rco_L !== 1'b1 || full !== 1'b1) begin
        failures++; $display("FAIL sat_hold i=%0d dout=%h rco=%b full=%b exp 9959/1/1", i, dout, rco_L, full);
      end
    end
    // Load landing on the pulse cycle ends the pulse.
    do_load(16'h9958);
    do_tick();
    do_load(16'h0500);
    tests_run++;
    if (rco_L !== 1'b1 || dout !== 16'h0500) begin
      failures++; $display("FAIL sat_load_in_pulse rco=%b dout=%h exp 1/0500", rco_L, dout);
    end
  endtask

  task automatic test_full_reload();
    do_load(16'h9958);
    do_tick();
    do_load(16'h1234);
    tests_run++;
    if (full !== 1'b0) begin failures++; $display("FAIL reload_full got=%b exp=0", full); end
    do_tick();
    tests_run++;
    if (dout !== 16'h1235) begin failures++; $display("FAIL reload_count got=%h exp=1235", dout); end
    do_load(16'h9959);
    tests_run++;
    if (full !== 1'b1 || rco_L !== 1'b1) begin
      failures++; $display("FAIL load_max full=%b rco=%b exp 1/1", full, rco_L);
    end
    do_tick();
    tests_run++;
    if (dout !== 16'h9959 || rco_L !== 1'b1) begin
      failures++; $display("FAIL load_max_tick dout=%h rco=%b exp 9959/1", dout, rco_L);
    end
    do_load(16'h9975);
    tests_run++;
    if (dout !== 16'h9959 || full !== 1'b1) begin
      failures++; $display("FAIL load_above_max dout=%h full=%b exp 9959/1", dout, full);
    end
    do_load(16'hFFFF);
    tests_run++;
    if (dout !== 16'h9959) begin failures++; $display("FAIL load_ffff got=%h exp=9959", dout); end
  endtask

  task automatic test_enable();
    do_load(16'h0420);
    enablen = 1'b1;
    repeat (5) do_tick();
    tests_run++;
    if (dout !== 16'h0420) begin failures++; $display("FAIL enable_freeze got=%h exp=0420", dout); end
    enablen = 1'b0;
    do_tick();
    tests_run++;
    if (dout !== 16'h0421) begin failures++; $display("FAIL enable_resume got=%h exp=0421", dout); end
  endtask

  task automatic test_load_tick();
    tick = 1'b1;
    do_load(16'h0100);
    tick = 1'b0;
    tests_run++;
    if (dout !== 16'h0100) begin failures++; $display("FAIL load_vs_tick got=%h exp=0100", dout); end
  endtask

  task automatic test_rst_tick();
    do_load(16'h0545);
    rst  = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    rst  = 1'b1;
    tick = 1'b0;
    tests_run++;
    if (dout !== 16'h0000 || rco_L !== 1'b1 || full !== 1'b0) begin
      failures++; $display("FAIL rst_vs_tick dout=%h rco=%b full=%b exp 0000/1/0", dout, rco_L, full);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_sec_rollover();
    test_tens_overflow();
    test_saturate();
    test_full_reload();
    test_enable();
    test_load_tick();
    test_rst_tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/timer_count_up.md
Name: timer_count_up

Overview:
- 4-digit BCD elapsed-time counter (MM:SS) for the P3 timer datapath. It is the up-counting counterpart of the seconds/minutes down-counter chain.
- Counts from a loaded value (default 00:00) toward a saturation limit, advancing one second per enabled tick.
- Flags saturation with an active-low ripple-carry pulse and a level `full` flag.
- Used for stopwatch/cook-elapsed display; outputs feed the same BCD display path as the down-counter.

Parameters:
- SEC_TENS_MAX, 5, largest tens-of-seconds value in normal counting (mod-6 digit).
- MAX_MIN, 8'h99, BCD minutes value at which the counter saturates (seconds saturate at 59).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset.
- load  input  1  active-high; captures din on the next clock edge.
- enablen  input  1  active-low count enable.
- tick  input  1  one-clk-wide 1 Hz pulse; counting advances only on cycles with tick=1.
- din  input  16  BCD load value {min_t, min_o, sec_t, sec_o}, 4 bits each.
- dout  output  16  current BCD count, same packing as din.
- full  output  1  high while dout == {MAX_MIN, 8'h59}.
- rco_L  output  1  registered, active-low, one-clk pulse on reaching saturation.

Behaviour:
- **Priority per edge:** rst=0 > load=1 > count advance. rst=0 forces dout=16'h0000, rco_L=1, state=COUNT, full=0.
- **Advance condition:** enablen=0 AND tick=1 AND state=COUNT AND load=0. Otherwise dout holds.
- **State machine:** states COUNT and FULL.
  - COUNT -> FULL on the advance that makes dout equal the max value.
  - FULL -> COUNT only via a load whose value is not the max value.
  - A load of exactly the max value enters FULL directly. rco_L stays 1 in that case; no pulse on load.
  - In FULL, advances are ignored and dout holds at max.
- **Digit arithmetic:** ripple cascade sec_o -> sec_t -> min_o -> min_t, evaluated in one cycle; dout updates on the same edge as the qualifying tick (latency 1 clk).
  - sec_o: 0..9, wraps 9->0 and carries.
  - sec_t: increments on carry. If sec_t >= SEC_TENS_MAX when a carry arrives, it wraps to 0 and carries into min_o. Consequences:
    - Loaded tens of 6..9 count ones up to 9, then roll to x0 of the next minute (e.g. 07:79 -> 08:00).
    - Exception: a loaded value of 6..9 with minutes already at MAX_MIN saturates at MAX_MIN:59 only by reload. Since the value 99:7x is above max, it is treated as max → FULL on load.
  - min_o: 0..9, wraps and carries into min_t.
  - min_t: 0..9.
- **Load sanitising:** any din nibble > 9 is loaded as 9. Any loaded value numerically >= max (compared in BCD) loads as max and enters FULL.
- **full:** combinational decode of dout == max. Valid in both states; equivalent to state==FULL.
- **rco_L:**
  - Driven 0 for exactly one clk on the cycle after the advance edge that enters FULL; returns to 1 the next edge.
  - If rst=0 or load=1 arrives during the pulse cycle, rco_L returns to 1 on that edge.
- **enablen:** enablen=1 freezes the count without loss. A tick arriving while enablen=1 is dropped, not deferred.
- **Simultaneous events:**
  - load and tick on the same edge: load wins, no increment applied.
  - rst mid-count: clears on that edge regardless of tick/load.
- No initial blocks. All registers reach defined values only through rst.

Test Plan:
- Reset then 10 enabled ticks -> dout steps 0000..0010; rco_L=1, full=0 throughout; each update one clk after tick.
- Load 16'h0759, one enabled tick -> dout=16'h0800; next tick -> 16'h0801.
- Load 16'h0279 (tens=7), three enabled ticks -> 0279 -> 0300 -> 0301 -> 0302; load 16'h0A5F -> dout=16'h0959 (sanitised).
- Load 16'h9958 (MAX_MIN=8'h99), tick -> dout=9959, full=1, rco_L=0 for exactly one clk. Further ticks -> dout holds 9959, rco_L stays 1.
- In FULL: load 16'h1234 -> state COUNT, full=0, next tick -> 1235. Load 16'h9959 -> full=1, no rco_L pulse.
- enablen=1 during 5 ticks -> dout unchanged. Tick coincident with load 16'h0100 -> dout=0100 (no increment). rst=0 coincident with tick at 0545 -> dout=0000.
